// File: rtl/exec_sequencer.sv
// Purpose: instruction sequencer (IDLE/EXEC/WAIT/HALT) driving PC write, commit enable and exception capture.
// Latency: step/load act one cycle after their registered rising edge; free-run issues one EXEC every RUN_DIV cycles.
// Backpressure: none; step/load are edge pulses, and a load arriving in EXEC is held pending for one cycle.
module exec_sequencer #(
   parameter int unsigned RUN_DIV = 4
) (
   input  logic        SYS_clk,
   input  logic        SYS_rst,
   input  logic        SYS_run,
   input  logic        SYS_step,
   input  logic        SYS_load,
   input  logic [7:0]  SYS_pc_val,
   input  logic [7:0]  PC_current,
   input  logic [7:0]  PC_next,
   input  logic        EH_flag,
   output logic        pc_en,
   output logic [7:0]  pc_val,
   output logic        wr_en,
   output logic [1:0]  seq_state,
   output logic [7:0]  EPC,
   output logic        EH_latched,
   output logic [15:0] instr_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_WAIT = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   // Last wait-counter value before issuing EXEC: WAIT lasts RUN_DIV-1 cycles.
   localparam logic [7:0] WAIT_LAST = 8'(RUN_DIV - 2);

   state_t     state;
   logic       step_r;
   logic       step_p;
   logic       load_r;
   logic       load_p;
   logic       load_pend;
   logic [7:0] wait_cnt;

   logic       step_edge;
   logic       load_edge;
   logic       load_act;
   logic       commit;

   assign seq_state = state;
   assign step_edge = step_r & ~step_p;
   assign load_edge = load_r & ~load_p;
   // A load is never serviced in EXEC; it is deferred through load_pend instead.
   assign load_act  = (state != ST_EXEC) & (load_edge | load_pend);
   assign commit    = (state == ST_EXEC) & ~EH_flag;

   // Output decode: load and commit are mutually exclusive by construction.
   always_comb begin
      pc_en  = load_act | commit;
      wr_en  = commit;
      pc_val = 8'h00;
      if (load_act) begin
         pc_val = SYS_pc_val;
      end else if (commit) begin
         pc_val = PC_next;
      end
   end

   // Register the request inputs and their previous values for edge detection.
   always_ff @(posedge SYS_clk or negedge SYS_rst) begin
      if (!SYS_rst) begin
         step_r <= 1'b0;
         step_p <= 1'b0;
         load_r <= 1'b0;
         load_p <= 1'b0;
      end else begin
         step_r <= SYS_step;
         step_p <= step_r;
         load_r <= SYS_load;
         load_p <= load_r;
      end
   end

   // Sequencer state, wait pacing, pending load, exception capture and commit counting.
   always_ff @(posedge SYS_clk or negedge SYS_rst) begin
      if (!SYS_rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= 8'h00;
         load_pend  <= 1'b0;
         EPC        <= 8'h00;
         EH_latched <= 1'b0;
         instr_cnt  <= 16'h0000;
      end else if (load_act) begin
         state      <= ST_IDLE;
         wait_cnt   <= 8'h00;
         load_pend  <= 1'b0;
         EH_latched <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (step_edge) begin
                  state <= ST_EXEC;
               end else if (SYS_run) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 8'h00;
               end
            end
            ST_EXEC: begin
               wait_cnt <= 8'h00;
               if (load_edge) begin
                  load_pend <= 1'b1;
               end
               if (EH_flag) begin
                  EPC        <= PC_current;
                  EH_latched <= 1'b1;
                  state      <= ST_HALT;
               end else begin
                  instr_cnt <= instr_cnt + 16'h0001;
                  state     <= SYS_run ? ST_WAIT : ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!SYS_run) begin
                  state    <= ST_IDLE;
                  wait_cnt <= 8'h00;
               end else if (wait_cnt == WAIT_LAST) begin
                  state    <= ST_EXEC;
                  wait_cnt <= 8'h00;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
